// File: rtl/load_use_interlock_unit.sv
// load_use_interlock_unit
// Load-use interlock between the IF/ID and ID/RR pipeline registers. It finds
// a load in ID/RR whose destination is a true source operand of the
// instruction in IF/ID. When it finds one, it holds PC and IF/ID for
// LOAD_STALL cycles and injects bubbles into ID/RR. A taken branch overrides
// the interlock and flushes IF/ID.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build a saturating stall-cycle
// counter. Without the macro, stall_cnt is constant zero and stall_cnt_clr is
// ignored.

module load_use_interlock_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead_id_rr,
    input  logic [REG_ADDR_W-1:0] rt_id_rr,
    input  logic [31:0]           Instruction_code_IfId,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush_IfId,
    input  logic                  stall_cnt_clr,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] HOLD_INIT = 4'(LOAD_STALL - 1);

    state_e                state_q;
    state_e                state_d;
    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rsAddr;
    logic [REG_ADDR_W-1:0] rtAddr;
    logic                  rtUsed;
    logic                  hazard;

    logic                  stallRaw;
    logic                  bubbleRaw;
    logic                  flushRaw;

    // The immediate / funct bits carry no register specifiers for this check
    logic                  unusedInstrBits;
    assign unusedInstrBits = ^Instruction_code_IfId[15:0];

    // Decode which fields of the IF/ID instruction are read as source operands
    always_comb begin
        opcode = Instruction_code_IfId[31:26];
        rsAddr = REG_ADDR_W'(Instruction_code_IfId[25:21]);
        rtAddr = REG_ADDR_W'(Instruction_code_IfId[20:16]);
        rtUsed = 1'b0;
        case (opcode)
            6'h00,
            6'h04,
            6'h05,
            6'h2B:   rtUsed = 1'b1;
            default: rtUsed = 1'b0;
        endcase
    end

    // Load-use comparison; register zero never produces a hazard
    always_comb begin
        hazard = 1'b0;
        if (MemRead_id_rr && (rt_id_rr != '0)) begin
            hazard = (rsAddr == rt_id_rr) || (rtUsed && (rtAddr == rt_id_rr));
        end
    end

    // Interlock state register with its remaining-hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and raw output decode; a taken branch wins over any stall
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stallRaw  = 1'b0;
        bubbleRaw = 1'b0;
        flushRaw  = 1'b0;

        if (branch_taken) begin
            flushRaw  = 1'b1;
            bubbleRaw = 1'b1;
            stallRaw  = 1'b0;
            state_d   = IDLE;
            cnt_d     = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    stallRaw  = hazard;
                    bubbleRaw = hazard;
                    if (hazard && (LOAD_STALL > 1)) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
                HOLD: begin
                    stallRaw  = 1'b1;
                    bubbleRaw = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // While reset is held all control outputs stay quiet
    always_comb begin
        stall      = rst_n & stallRaw;
        bubble     = rst_n & bubbleRaw;
        flush_IfId = rst_n & flushRaw;
    end

`ifdef HAZARD_PERF_CNT_EN

    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] stallCnt_d;

    // Saturating stall-cycle count; the clear wins over the increment
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_cnt_clr) begin
            stallCnt_d = '0;
        end else if (stall && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;

`else

    logic unusedStallCntClr;
    assign unusedStallCntClr = stall_cnt_clr;

    assign stall_cnt = '0;

`endif

endmodule

// File: tb/tb_load_use_interlock_unit.sv
// tb_load_use_interlock_unit
// Four interlock instances with different stall depths share one input stream.
// A behavioural model holds, for each instance, the number of stall cycles
// still owed and the expected counter value. It predicts stall, bubble,
// flush_IfId and stall_cnt for every cycle.

module tb_load_use_interlock_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead;
    logic [4:0]  rtIdRr;
    logic [31:0] instr;
    logic        branch;
    logic        cntClr;

    logic [3:0]  stallV;
    logic [3:0]  bubbleV;
    logic [3:0]  flushV;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;
    logic [1:0]  cnt3;
    logic [15:0] cntObs [4];

    int checks = 0;
    int errors = 0;

    localparam int LS     [4] = '{1, 3, 4, 5};
    localparam int CNTMAX [4] = '{65535, 65535, 65535, 3};

    int remM [4];
    int cntM [4];

    always #5 clk = ~clk;

    load_use_interlock_unit #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .MemRead_id_rr(memRead), .rt_id_rr(rtIdRr),
        .Instruction_code_IfId(instr), .branch_taken(branch), .stall(stallV[0]),
        .bubble(bubbleV[0]), .flush_IfId(flushV[0]), .stall_cnt_clr(cntClr),
        .stall_cnt(cnt0));

    load_use_interlock_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .MemRead_id_rr(memRead), .rt_id_rr(rtIdRr),
        .Instruction_code_IfId(instr), .branch_taken(branch), .stall(stallV[1]),
        .bubble(bubbleV[1]), .flush_IfId(flushV[1]), .stall_cnt_clr(cntClr),
        .stall_cnt(cnt1));

    load_use_interlock_unit #(.REG_ADDR_W(5), .LOAD_STALL(4), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .MemRead_id_rr(memRead), .rt_id_rr(rtIdRr),
        .Instruction_code_IfId(instr), .branch_taken(branch), .stall(stallV[2]),
        .bubble(bubbleV[2]), .flush_IfId(flushV[2]), .stall_cnt_clr(cntClr),
        .stall_cnt(cnt2));

    load_use_interlock_unit #(.REG_ADDR_W(5), .LOAD_STALL(5), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .MemRead_id_rr(memRead), .rt_id_rr(rtIdRr),
        .Instruction_code_IfId(instr), .branch_taken(branch), .stall(stallV[3]),
        .bubble(bubbleV[3]), .flush_IfId(flushV[3]), .stall_cnt_clr(cntClr),
        .stall_cnt(cnt3));

    // Gather counter outputs into one array for indexed checking
    always_comb begin
        cntObs[0] = cnt0;
        cntObs[1] = cnt1;
        cntObs[2] = cnt2;
        cntObs[3] = {14'd0, cnt3};
    end

    // A hazard exists when the loaded register is read by the IF/ID instruction
    function automatic bit refHazard();
        logic [5:0] op;
        bit         rtIsSource;
        op         = instr[31:26];
        rtIsSource = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        if (!memRead || rtIdRr == 5'd0) return 1'b0;
        return (instr[25:21] == rtIdRr) || (rtIsSource && instr[20:16] == rtIdRr);
    endfunction

    function automatic bit expStall(int i);
        if (!rst_n || branch) return 1'b0;
        if (remM[i] > 0) return 1'b1;
        return refHazard();
    endfunction

    function automatic bit expBubble(int i);
        if (!rst_n) return 1'b0;
        if (branch) return 1'b1;
        return expStall(i);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            remM[i] = 0;
            cntM[i] = 0;
        end
    endtask

    // Advance the model across one rising clock edge
    task automatic modelEdge();
        bit s;
        if (!rst_n) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            s = expStall(i);
`ifdef HAZARD_PERF_CNT_EN
            if (cntClr) cntM[i] = 0;
            else if (s && cntM[i] < CNTMAX[i]) cntM[i] = cntM[i] + 1;
`endif
            if (branch) remM[i] = 0;
            else if (remM[i] > 0) remM[i] = remM[i] - 1;
            else if (refHazard()) remM[i] = LS[i] - 1;
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string step);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.u%0d.stall", step, i), 32'(stallV[i]), 32'(expStall(i)));
            checkOutput($sformatf("%s.u%0d.bubble", step, i), 32'(bubbleV[i]), 32'(expBubble(i)));
            checkOutput($sformatf("%s.u%0d.flush", step, i), 32'(flushV[i]), 32'(rst_n & branch));
            checkOutput($sformatf("%s.u%0d.cnt", step, i), 32'(cntObs[i]), 32'(cntM[i]));
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step the model at the edge
    task automatic applyStimulus(string step, logic rn, logic mr, logic [4:0] rt,
                                 logic [31:0] ins, logic br, logic clr);
        rst_n   = rn;
        memRead = mr;
        rtIdRr  = rt;
        instr   = ins;
        branch  = br;
        cntClr  = clr;
        @(negedge clk);
        checkAll(step);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    logic [5:0] ops [6] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};

    initial begin
        modelReset();
        rst_n   = 1'b0;
        memRead = 1'b1;
        rtIdRr  = 5'd9;
        instr   = 32'h012B5020;
        branch  = 1'b0;
        cntClr  = 1'b0;

        // Reset held with a hazard present: everything quiet
        applyStimulus("rst", 1'b0, 1'b1, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("rst2", 1'b0, 1'b1, 5'd9, 32'h012B5020, 1'b1, 1'b0);

        // add $10,$9,$11 after a load into $9, hazard for one cycle
        applyStimulus("addHaz", 1'b1, 1'b1, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("addTail%0d", k), 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);

        // addi writes rt, so rt is not a source; register zero never hazards
        applyStimulus("addiRt", 1'b1, 1'b1, 5'd10, 32'h216A0005, 1'b0, 1'b0);
        applyStimulus("zeroReg", 1'b1, 1'b1, 5'd0, 32'h00005020, 1'b0, 1'b0);
        // sw uses rt as a source
        applyStimulus("swRt", 1'b1, 1'b1, 5'd10, 32'hAD6A0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("swTail%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Hazard, then a taken branch in the second HOLD cycle
        applyStimulus("brHaz", 1'b1, 1'b1, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("brHold1", 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("brHold2", 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b1, 1'b0);
        applyStimulus("brAfter", 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("brAfter2", 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);

        // Hazard, then asynchronous reset in the middle of HOLD
        applyStimulus("arHaz", 1'b1, 1'b1, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("arHold", 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);
        rst_n = 1'b0;
        modelReset();
        #2;
        checkAll("arAsync");
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            applyStimulus($sformatf("arRel%0d", k), 1'b1, 1'b0, 5'd9, 32'h012B5020, 1'b0, 1'b0);

        // Long run of stall cycles saturates the narrow counter, then clear wins
        for (int k = 0; k < 6; k++)
            applyStimulus($sformatf("sat%0d", k), 1'b1, 1'b1, 5'd11, 32'h012B5020, 1'b0, 1'b0);
        applyStimulus("satClr", 1'b1, 1'b1, 5'd11, 32'h012B5020, 1'b0, 1'b1);
        applyStimulus("satAfter", 1'b1, 1'b0, 5'd11, 32'h012B5020, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("drain%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic over a small register window to make hazards common
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ins;
            ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom)};
            applyStimulus($sformatf("rnd%0d", k),
                          ($urandom_range(0, 49) != 0),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)),
                          ins,
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
